// File: rtl/klein_pkg.sv
// Shared types and constants for the KLEIN-64 serial sequencer.
package klein_pkg;

    localparam int KLEIN_BLOCK_W = 64;
    localparam int KLEIN_BYTE_W  = 8;
    localparam int KLEIN_NBYTES  = 8;

    // Controller phases: idle/accept, feed core, wait on core, gather result.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        WAIT    = 2'd2,
        COLLECT = 2'd3
    } klein_state_e;

endpackage

// File: rtl/klein_byte_shifter.sv
// Per-lane 64-bit byte shifter: parallel load, shift one byte toward the MSB
// end while inserting a byte at the LSB end. The top byte is the serial output
// and the whole vector is the parallel output, so one lane serves either as a
// serialiser (load + shift out) or as a deserialiser (shift in + read).
module klein_byte_shifter
    import klein_pkg::*;
#(
    parameter int NUM_LANES = 1,
    parameter int VEC_W     = KLEIN_BLOCK_W,
    parameter int BYTE_W    = KLEIN_BYTE_W
) (
    input  logic                                ck,
    input  logic                                rst_n,
    input  logic                                i_load,
    input  logic [NUM_LANES-1:0][VEC_W-1:0]     i_par,
    input  logic                                i_shift,
    input  logic [NUM_LANES-1:0][BYTE_W-1:0]    i_byte,
    output logic [NUM_LANES-1:0][BYTE_W-1:0]    o_byte,
    output logic [NUM_LANES-1:0][VEC_W-1:0]     o_par
);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [VEC_W-1:0] r_vec;

        // Parallel load wins over shift; a shift drops the top byte.
        always_ff @(posedge ck or negedge rst_n) begin
            if (!rst_n) begin
                r_vec <= '0;
            end else if (i_load) begin
                r_vec <= i_par[g];
            end else if (i_shift) begin
                r_vec <= {r_vec[VEC_W-BYTE_W-1:0], i_byte[g]};
            end
        end

        assign o_byte[g] = r_vec[VEC_W-1 -: BYTE_W];
        assign o_par[g]  = r_vec;
    end

endmodule

// File: rtl/klein64_serial_ctrl.sv
// Sequencer around the byte-serial KLEIN-64 core: accepts block+key, streams
// them into the core over 8 cycles, waits under a watchdog, gathers the 8
// result bytes and holds the ciphertext until the consumer takes it.
module klein64_serial_ctrl
    import klein_pkg::*;
#(
    parameter int NBYTES  = KLEIN_NBYTES,
    parameter int TIMEOUT = 1023,
    parameter int CW      = 10
) (
    input  logic        ck,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_block,
    input  logic [63:0] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_block,
    output logic        busy,
    output logic        err,
    output logic        core_start,
    output logic [7:0]  core_inp,
    output logic [7:0]  core_key,
    input  logic        core_ready,
    input  logic [7:0]  core_out
);

    localparam int              CNTW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NBYTES - 1);
    localparam logic [CW-1:0]   WD_ONE   = CW'(1);
    // Watchdog holds the number of WAIT cycles already completed, so the
    // TIMEOUT-th WAIT cycle is the one that sees TIMEOUT-1.
    localparam logic [CW-1:0]   WD_LAST  = CW'(TIMEOUT - 1);

    klein_state_e     r_state, w_nxt_state;
    logic [CNTW-1:0]  r_cnt, w_cnt_nxt;
    logic [CW-1:0]    r_wdog, w_wdog_nxt;
    logic             r_err, w_err_nxt;
    logic             r_out_valid, w_ov_nxt;
    logic [63:0]      r_out_block;
    logic             r_live;

    logic             w_accept;
    logic             w_src_load, w_src_shift, w_res_shift, w_ob_load;
    logic [1:0][7:0]  w_src_byte;
    logic [1:0][63:0] w_src_par_unused;
    logic [0:0][7:0]  w_res_byte_unused;
    logic [0:0][63:0] w_res_par;

    // Block (lane 0) and key (lane 1) serialiser; top byte goes to the core.
    klein_byte_shifter #(.NUM_LANES(2)) u_src (
        .ck      (ck),
        .rst_n   (rst_n),
        .i_load  (w_src_load),
        .i_par   ({in_key, in_block}),
        .i_shift (w_src_shift),
        .i_byte  ('0),
        .o_byte  (w_src_byte),
        .o_par   (w_src_par_unused)
    );

    // Result deserialiser; byte 0 ends up in the top byte after 8 shifts.
    klein_byte_shifter #(.NUM_LANES(1)) u_res (
        .ck      (ck),
        .rst_n   (rst_n),
        .i_load  (1'b0),
        .i_par   ('0),
        .i_shift (w_res_shift),
        .i_byte  (core_out),
        .o_byte  (w_res_byte_unused),
        .o_par   (w_res_par)
    );

    // r_live keeps in_ready low while in reset and until the first clock after.
    assign in_ready  = r_live && (r_state == IDLE) && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign busy      = (r_state != IDLE);
    assign err       = r_err;
    assign out_valid = r_out_valid;
    assign out_block = r_out_block;

    // Next-state, counter, flag and core-drive logic.
    always_comb begin
        w_nxt_state = r_state;
        w_cnt_nxt   = r_cnt;
        w_wdog_nxt  = r_wdog;
        w_err_nxt   = r_err;
        w_ov_nxt    = r_out_valid && !out_ready;
        w_src_load  = 1'b0;
        w_src_shift = 1'b0;
        w_res_shift = 1'b0;
        w_ob_load   = 1'b0;
        core_start  = 1'b0;
        core_inp    = '0;
        core_key    = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_src_load  = 1'b1;
                    w_err_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    w_nxt_state = LOAD;
                end
            end
            LOAD: begin
                core_start  = (r_cnt == '0);
                core_inp    = w_src_byte[0];
                core_key    = w_src_byte[1];
                w_src_shift = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_wdog_nxt  = '0;
                    w_nxt_state = WAIT;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            WAIT: begin
                w_wdog_nxt = r_wdog + WD_ONE;
                // A strobe on the last allowed cycle still counts as on time.
                if (core_ready) begin
                    w_res_shift = 1'b1;
                    w_cnt_nxt   = CNT_ONE;
                    w_nxt_state = COLLECT;
                end else if (r_wdog == WD_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_nxt_state = IDLE;
                end
            end
            COLLECT: begin
                if (!core_ready) begin
                    // Core stream broke early; the partial result is dropped.
                    w_err_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_nxt_state = IDLE;
                end else begin
                    w_res_shift = 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        w_ob_load   = 1'b1;
                        w_ov_nxt    = 1'b1;
                        w_cnt_nxt   = '0;
                        w_nxt_state = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    // State, counters, sticky error and the held output block.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_wdog      <= '0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_block <= '0;
            r_live      <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_cnt_nxt;
            r_wdog      <= w_wdog_nxt;
            r_err       <= w_err_nxt;
            r_out_valid <= w_ov_nxt;
            r_live      <= 1'b1;
            // Last byte comes straight from the core; the other 7 are shifted in.
            if (w_ob_load) begin
                r_out_block <= {w_res_par[0][55:0], core_out};
            end
        end
    end

endmodule

// File: tb/tb_klein64_serial_ctrl.sv
// Bench for klein64_serial_ctrl: behavioural core stub (result = inp ^ key),
// scoreboard queue of expected outcomes, separate monitor process.
module tb_klein64_serial_ctrl;

    localparam int TO     = 30;
    localparam int M_OK    = 0;
    localparam int M_NEVER = 1;
    localparam int M_DROP  = 2;

    logic        ck = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_block = '0;
    logic [63:0] in_key = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_block;
    logic        busy, err, core_start;
    logic [7:0]  core_inp, core_key;
    logic        core_ready;
    logic [7:0]  core_out;

    klein64_serial_ctrl #(.NBYTES(8), .TIMEOUT(TO), .CW(10)) dut (
        .ck(ck), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
        .busy(busy), .err(err),
        .core_start(core_start), .core_inp(core_inp), .core_key(core_key),
        .core_ready(core_ready), .core_out(core_out)
    );

    always #5 ck = ~ck;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int stub_mode = M_OK;
    int stub_w    = 20;
    bit rnd_rdy   = 1'b0;

    typedef struct {
        bit          is_err;
        logic [63:0] data;
        int          acc;
        int          lat;
    } exp_t;
    exp_t q[$];

    initial forever begin
        @(posedge ck);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Core stub: samples 8 bytes from the start cycle, answers 8+W cycles later.
    initial begin : stub
        int t0;
        int k;
        int smode;
        int sw;
        logic [7:0] sb [8];
        t0 = -1000; smode = M_OK; sw = 0;
        core_ready = 1'b0; core_out = '0;
        for (int i = 0; i < 8; i++) sb[i] = '0;
        forever begin
            @(negedge ck);
            if (core_start) begin
                t0 = cyc; smode = stub_mode; sw = stub_w;
            end
            if (t0 >= 0 && cyc - t0 < 8) sb[cyc - t0] = core_inp ^ core_key;
            k = cyc - (t0 + 8 + sw);
            core_ready = 1'b0; core_out = '0;
            if (smode != M_NEVER && k >= 0 && k < ((smode == M_DROP) ? 4 : 8)) begin
                core_ready = 1'b1; core_out = sb[k];
            end
        end
    end

    // Monitor: every new result or new error must match the queue head.
    initial begin : mon
        exp_t e;
        bit pv, pe;
        pv = 1'b0; pe = 1'b0;
        forever begin
            @(negedge ck);
            if (rst_n) begin
                if (out_valid && !pv) begin
                    if (q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_result: got %h want none", out_block);
                    end else begin
                        e = q.pop_front();
                        chk("result_kind", {63'd0, 1'b0}, {63'd0, e.is_err});
                        chk("result_data", out_block, e.data);
                        chk("result_latency", 64'(cyc - e.acc), 64'(e.lat));
                        chk("result_err", {63'd0, err}, 64'd0);
                    end
                end
                if (err && !pe) begin
                    if (q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_err: got 1 want 0");
                    end else begin
                        e = q.pop_front();
                        chk("err_kind", {63'd0, 1'b1}, {63'd0, e.is_err});
                        chk("err_latency", 64'(cyc - e.acc), 64'(e.lat));
                        chk("err_out_valid", {63'd0, out_valid}, 64'd0);
                    end
                end
                pv = out_valid; pe = err;
            end else begin
                pv = 1'b0; pe = 1'b0;
            end
        end
    end

    // Random downstream backpressure, changed away from the sampling edge.
    initial forever begin
        @(posedge ck);
        #2;
        if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [63:0] b, input logic [63:0] k, input int m, input int w);
        exp_t e;
        int n;
        @(negedge ck);
        in_block = b; in_key = k; in_valid = 1'b1; stub_mode = m; stub_w = w;
        n = 0;
        while (!in_ready && n < 2000) begin
            @(negedge ck);
            n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: in_ready got 0 want 1");
        end else begin
            e.is_err = (m != M_OK);
            e.data   = b ^ k;
            e.acc    = cyc;
            e.lat    = (m == M_NEVER) ? (9 + TO) : (m == M_DROP) ? (14 + w) : (17 + w);
            q.push_back(e);
        end
        @(posedge ck);
        #1;
        in_valid = 1'b0;
    endtask

    // Checks the 8 serial bytes and the single start pulse, then idle drive.
    task automatic observe_load(input logic [63:0] b, input logic [63:0] k);
        for (int i = 0; i < 8; i++) begin
            @(negedge ck);
            chk("core_start", {63'd0, core_start}, {63'd0, (i == 0)});
            chk("core_inp", {56'd0, core_inp}, {56'd0, b[63-8*i -: 8]});
            chk("core_key", {56'd0, core_key}, {56'd0, k[63-8*i -: 8]});
        end
        @(negedge ck);
        chk("start_after_load", {63'd0, core_start}, 64'd0);
        chk("inp_after_load", {56'd0, core_inp}, 64'd0);
        chk("key_after_load", {56'd0, core_key}, 64'd0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge ck);
            n++;
        end
        if (q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: pending got %0d want 0", q.size());
        end
        repeat (2) @(negedge ck);
    endtask

    task automatic wait_err(input string tag);
        int n;
        n = 0;
        while (!err && n < 200) begin
            @(negedge ck);
            n++;
        end
        chk({tag, "_err"}, {63'd0, err}, 64'd1);
        chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
        chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_out_block"}, out_block, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_err"}, {63'd0, err}, 64'd0);
        chk({tag, "_core_start"}, {63'd0, core_start}, 64'd0);
        chk({tag, "_core_inp"}, {56'd0, core_inp}, 64'd0);
        chk({tag, "_core_key"}, {56'd0, core_key}, 64'd0);
    endtask

    task automatic mid_reset(input string tag, input int wait_cyc);
        repeat (wait_cyc) @(negedge ck);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero(tag);
        void'(q.pop_back());
        repeat (2) @(negedge ck);
        rst_n = 1'b1;
        repeat (40) @(negedge ck);
    endtask

    initial begin : guard
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        logic [63:0] a, b, k;
        int m, w;
        repeat (3) @(negedge ck);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge ck);

        // All-ones key over zero block.
        send(64'h0, 64'hFFFF_FFFF_FFFF_FFFF, M_OK, 20);
        observe_load(64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_idle();

        // Byte ordering on core_inp.
        send(64'h1234_5678_90AB_CDEF, 64'h0, M_OK, 20);
        observe_load(64'h1234_5678_90AB_CDEF, 64'h0);
        wait_idle();

        // Backpressure: result held, new block waits, then drain+accept together.
        a = 64'hA5A5_0F0F_3C3C_9696; k = 64'h0123_4567_89AB_CDEF;
        send(a, k, M_OK, 7);
        out_ready = 1'b0;
        observe_load(a, k);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 100) begin
                @(negedge ck);
                n++;
            end
        end
        b = 64'hDEAD_BEEF_CAFE_F00D;
        in_block = b; in_key = k; in_valid = 1'b1; stub_mode = M_OK; stub_w = 4;
        for (int i = 0; i < 50; i++) begin
            @(negedge ck);
            chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
            chk("hold_out_block", out_block, a ^ k);
        end
        out_ready = 1'b1;
        #1;
        chk("drain_in_ready", {63'd0, in_ready}, 64'd1);
        begin
            exp_t e;
            e.is_err = 1'b0; e.data = b ^ k; e.acc = cyc; e.lat = 21;
            q.push_back(e);
        end
        @(posedge ck);
        #1;
        in_valid = 1'b0;
        chk("drain_out_valid", {63'd0, out_valid}, 64'd0);
        chk("drain_busy", {63'd0, busy}, 64'd1);
        observe_load(b, k);
        wait_idle();

        // Watchdog timeout, then the next block clears err.
        send(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, M_NEVER, 0);
        wait_err("timeout");
        send(64'h0F1E_2D3C_4B5A_6978, 64'hFFFF_0000_FFFF_0000, M_OK, 12);
        chk("err_cleared", {63'd0, err}, 64'd0);
        wait_idle();

        // Core stream drops after 4 bytes.
        send(64'h8877_6655_4433_2211, 64'h0, M_DROP, 5);
        wait_err("drop");
        wait_idle();

        // Asynchronous reset during WAIT and during COLLECT.
        send(64'hCAFE_BABE_1234_5678, 64'h1, M_OK, 20);
        mid_reset("rst_wait", 13);
        send(64'hFACE_B00C_8765_4321, 64'h2, M_OK, 3);
        mid_reset("rst_collect", 13);
        send(64'h0BAD_F00D_5EED_1DEA, 64'h7777_1111_3333_5555, M_OK, 9);
        wait_idle();

        // Randomized traffic with random backpressure and occasional core faults.
        rnd_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = {$urandom, $urandom};
            k = {$urandom, $urandom};
            m = $urandom_range(0, 9);
            m = (m == 0) ? M_NEVER : (m == 1) ? M_DROP : M_OK;
            w = $urandom_range(0, 25);
            send(a, k, m, w);
            observe_load(a, k);
        end
        rnd_rdy = 1'b0;
        @(posedge ck);
        #2;
        out_ready = 1'b1;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/klein64_serial_ctrl.md
Name: klein64_serial_ctrl

Overview:
Sequencer wrapping the byte-serial KLEIN-64 core (klein_64). It accepts a 64-bit block and key over a valid/ready handshake, serialises both into the core over 8 cycles, and waits for core completion under a watchdog. It then deserialises the 8 ciphertext bytes and holds the result until the downstream consumer takes it. It sits between the system bus/DMA and the core, and isolates the core's non-stallable serial timing from the rest of the design.

Parameters:
NBYTES, 8, bytes per block/key; fixed for KLEIN-64, used only for counter sizing
TIMEOUT, 1023, maximum cycles in WAIT before err; must be >= 1
CW, 10, width of the watchdog counter; must satisfy 2**CW > TIMEOUT

Ports:
ck  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream offers in_block/in_key
in_ready  out  1  controller accepts this cycle
in_block  in  64  plaintext; [63:56] is byte 0, sent first
in_key  in  64  key; same byte order
out_valid  out  1  out_block holds a result
out_ready  in  1  downstream takes the result
out_block  out  64  ciphertext; byte 0 in [63:56]
busy  out  1  high in LOAD/WAIT/COLLECT
err  out  1  sticky watchdog timeout flag
core_start  out  1  one-cycle start pulse to the core
core_inp  out  8  serial data byte to the core
core_key  out  8  serial key byte to the core
core_ready  in  1  core result strobe
core_out  in  8  serial result byte from the core

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=0, out_valid=0, out_block=0, busy=0, err=0, core_start=0, core_inp=0, core_key=0; all counters=0. Reset mid-operation abandons the block. The core is not reset by this block.
- in_ready = (state==IDLE) && (!out_valid || out_ready). It is combinational from registered state and out_ready.
- Core protocol (fixed): the core samples core_inp/core_key on the core_start cycle and on the 7 following cycles, byte 0 first. It asserts core_ready for exactly 8 consecutive cycles, presenting result byte k on the k-th cycle. The core cannot stall, so the controller must never backpressure it.
- IDLE: on in_valid && in_ready, latch in_block/in_key into shift registers, clear err, and go to LOAD with byte counter=0.
- LOAD (8 cycles): drive core_inp/core_key with byte[cnt]. core_start=1 only when cnt==0. After cnt==7, go to WAIT with watchdog=0.
- WAIT: watchdog increments each cycle.
  - If core_ready=1, capture core_out as byte 0 and go to COLLECT with cnt=1.
  - Else if watchdog==TIMEOUT, set err=1, go to IDLE, and do not set out_valid.
  - core_ready seen in IDLE or LOAD is ignored.
- COLLECT: capture core_out into byte[cnt] each cycle. After byte 7 is captured, load the 64-bit result into out_block, set out_valid=1, and go to IDLE.
  - If core_ready drops before byte 7, set err=1, discard the partial result, and go to IDLE.
- out_valid clears on out_valid && out_ready. A new result cannot arrive while out_valid=1, because acceptance requires the output to be free or draining. A simultaneous drain and acceptance is legal.
- Latency: from acceptance to out_valid = 8 (LOAD) + W (core latency, counted in WAIT cycles) + 8 (COLLECT) + 1 cycles.
- Throughput: one block in flight at a time; back-to-back acceptance is possible on the cycle out_valid drains.
- core_inp/core_key hold 0 outside LOAD.

Decomposition:
- Package klein_pkg: state enum (IDLE, LOAD, WAIT, COLLECT); constants KLEIN_BLOCK_W=64, KLEIN_BYTE_W=8, KLEIN_NBYTES=8.
- Sub-module klein_byte_shifter: 64-bit load-parallel/shift-out-byte register plus shift-in-byte/read-parallel register. It is instantiated once for the inp/key pair and once for the result.
- The FSM and watchdog stay in the top module.

Test Plan:
- Use a core stub that returns inp^key bytes after W=20 cycles. Send in_block=0x0000000000000000, in_key=0xFFFFFFFFFFFFFFFF -> core_start high exactly 1 cycle; core_key=0xFF for 8 cycles; out_block=0xFFFFFFFFFFFFFFFF with out_valid at cycle 37 after acceptance; err=0.
- Send in_block=0x1234567890ABCDEF, key=0 -> core_inp sequence 12,34,56,78,90,AB,CD,EF; out_block=0x1234567890ABCDEF.
- Hold out_ready=0 for 50 cycles with in_valid held -> in_ready=0 and out_block stable. Raise out_ready -> drain and the next acceptance occur in the same cycle.
- Stub never asserts core_ready with TIMEOUT=30 -> err=1 exactly 30 WAIT cycles after entry, out_valid stays 0, in_ready=1 next cycle. The next accepted block clears err.
- Stub drops core_ready after 4 bytes -> err=1, no out_valid, return to IDLE.
- Assert rst_n=0 during WAIT and during COLLECT -> all outputs 0 immediately (asynchronously). After release, a fresh block completes correctly.
